pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register. It is the successor to the fixed-width EX/MEM latch and is intended to replace the per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready flow control, hazard stall, synchronous flush/bubble insertion and an optional 2-entry skid buffer.
- Sits between two pipeline stages. Carries a control word, N data words and a destination register index.

Parameters:
- DATA_W, 32: width of each data word.
- NUM_DATA, 3: number of data words carried (e.g. pc+4, alu result, store data).
- CTRL_W, 8: control word width.
- REG_W, 5: destination register index width.
- CTRL_NOP, 1: control value loaded on reset/flush; marks a bubble.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous flush; converts all held entries to bubbles.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept an entry this cycle.
- in_ctrl, input, CTRL_W: upstream control word.
- in_data, input, NUM_DATA*DATA_W: upstream data words, word 0 in the LSBs.
- in_regdst, input, REG_W: upstream destination register.
- out_valid, output, 1: entry presented downstream.
- out_ready, input, 1: downstream accepts (0 = stall).
- out_ctrl, output, CTRL_W: control word of the head entry.
- out_data, output, NUM_DATA*DATA_W: data words of the head entry.
- out_regdst, output, REG_W: destination register of the head entry.
- occupancy, output, 2: number of entries held (0..2; max 1 when SKID=0).

Behaviour:
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Retire occurs when out_valid && out_ready.
  - in_valid may drop without waiting for in_ready; no payload stability is required upstream.
- Reset (reset=0, asynchronous):
  - out_valid=0, out_ctrl=CTRL_NOP, out_data=0, out_regdst=0.
  - Skid entry cleared to the same values; occupancy=0.
  - in_ready=1 once reset is released (SKID=1: in_ready=1 during reset as well).
- Bubble rule: whenever out_valid=0, out_ctrl=CTRL_NOP, out_data=0 and out_regdst=0. Downstream may ignore out_valid and decode ctrl alone.
- Storage: a head register drives the outputs; with SKID=1 a skid register backs it.
- SKID=1 transitions, all at the posedge:
  - Empty: an accept loads the head; out_valid=1 in the next cycle (latency 1).
  - Head full, retire and accept together: the head reloads from input; throughput is 1 entry per cycle.
  - Head full, no retire, accept: the entry goes to the skid register; occupancy=2.
  - Occupancy 2 and retire: the skid entry moves into the head; the skid register is cleared to NOP.
  - in_ready is a register equal to !(skid full after this edge), so it has no combinational path from out_ready.
  - An accept while occupancy=2 cannot happen, because in_ready=0.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - The head loads on accept; it holds while out_valid && !out_ready.
  - If there is a retire with no accept, the head becomes a bubble.
- Flush (sampled at posedge):
  - Both entries become bubbles and occupancy=0.
  - An accept in the same cycle is discarded; flush wins over accept, retire and stall.
  - in_ready=1 the cycle after a flush.
- Reset asserted mid-transfer: all state clears immediately; the partially accepted entry is lost, with no error signalled.
- Data ordering is strictly FIFO. No entry is duplicated or dropped except by flush or reset.
- occupancy counts 0->1->2 and never wraps. Accept and retire in the same cycle leave it unchanged.

Decomposition:
- Shared package: CTRL_NOP default, control-field bit positions, and a typed payload struct {ctrl, data[NUM_DATA], regdst}.
- One natural sub-module: pipe_entry_reg, a payload register with load, clear-to-NOP and async reset. It is instantiated twice (head, skid) when SKID=1 and once when SKID=0.

Test Plan:
1. Reset: hold reset=0 and drive inputs at random -> out_valid=0, out_ctrl=8'h01, out_data=0, out_regdst=0, occupancy=0; after release, in_ready=1.
2. Streaming: out_ready=1; send ctrl=8'h10..8'h17 on consecutive cycles with data word0 = index -> identical sequence appears one cycle later, one per cycle, with no gaps.
3. Stall/skid: with the head holding A (ctrl 8'h22), drop out_ready and send B (8'h33) -> occupancy=2, in_ready=0 next cycle, out_ctrl stays 8'h22; raise out_ready -> A then B, then occupancy=0.
4. Flush priority: occupancy=2 and in_valid=1 with C; pulse flush -> next cycle out_valid=0, out_ctrl=8'h01, occupancy=0, C is never output.
5. Async reset mid-stall: occupancy=2; assert reset between edges -> outputs go to reset values without a clock edge.
6. SKID=0 build: repeat scenarios 2 and 3 -> in_ready tracks out_ready combinationally, occupancy never exceeds 1, order is preserved.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared definitions for the generic inter-stage
// pipeline register.
//  - Default widths used as parameter defaults by pipe_stage_reg.
//  - Control-word field positions; the bubble marker defines CTRL_NOP.
//  - payload_t: typed view of one entry {ctrl, data[NUM_DATA], regdst} at
//    the default widths, with word 0 in the LSBs of data.
package pipe_stage_reg_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_DATA_DEF = 3;
  localparam int CTRL_W_DEF   = 8;
  localparam int REG_W_DEF    = 5;

  // Control-word field: bit set only in a bubble (no architectural effect).
  localparam int CTRL_BUBBLE_BIT = 0;

  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP_DEF =
    {{(CTRL_W_DEF-1){1'b0}}, 1'b1} << CTRL_BUBBLE_BIT;

  typedef struct packed {
    logic [CTRL_W_DEF-1:0]                     ctrl;
    logic [NUM_DATA_DEF-1:0][DATA_W_DEF-1:0]   data;
    logic [REG_W_DEF-1:0]                      regdst;
  } payload_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one payload register of the pipeline stage.
//  clk     - rising-edge clock
//  reset   - asynchronous active-low reset, loads NOP_VAL
//  load    - capture d at the next edge
//  clear   - overwrite with NOP_VAL at the next edge (wins over load)
//  d / q   - flat payload in / out
module pipe_entry_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int           W       = 8,
  parameter logic [W-1:0] NOP_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Payload storage: clear-to-bubble has priority over a load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= NOP_VAL;
    end else if (clear) begin
      q <= NOP_VAL;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with valid/ready
// flow control, synchronous flush and an optional 2-entry skid buffer.
//  clk, reset (async active-low), flush (sync, turns held entries to bubbles)
//  in_valid/in_ready/in_ctrl/in_data/in_regdst     - upstream side
//  out_valid/out_ready/out_ctrl/out_data/out_regdst - downstream side (head)
//  occupancy - number of entries held (0..2)
// The head register always drives the outputs; it is forced to the bubble
// value whenever it holds no valid entry, so downstream may decode ctrl alone.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                NUM_DATA = NUM_DATA_DEF,
  parameter int                CTRL_W   = CTRL_W_DEF,
  parameter int                REG_W    = REG_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEF),
  parameter int                SKID     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]           in_regdst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [REG_W-1:0]           out_regdst,
  output logic [1:0]                 occupancy
);

  localparam int PW = CTRL_W + NUM_DATA*DATA_W + REG_W;
  localparam logic [PW-1:0] NOP_PAYLOAD = {CTRL_NOP, {(NUM_DATA*DATA_W+REG_W){1'b0}}};

  logic          accept, retire;
  logic [PW-1:0] in_pl, head_d, head_q, skid_q;
  logic          head_valid, skid_valid;
  logic          head_valid_nxt, skid_valid_nxt;
  logic          head_load, head_clear, skid_load, skid_clear;

  assign in_pl  = {in_ctrl, in_data, in_regdst};
  assign accept = in_valid && in_ready;
  assign retire = head_valid && out_ready;
  // A pending skid entry always has precedence over the input for the head.
  assign head_d = skid_valid ? skid_q : in_pl;

  // Next-state decode for head/skid occupancy and register controls.
  always_comb begin
    head_load      = 1'b0;
    head_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    head_valid_nxt = head_valid;
    skid_valid_nxt = skid_valid;
    if (flush) begin
      head_clear     = 1'b1;
      skid_clear     = 1'b1;
      head_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (skid_valid) begin
      // Full: in_ready is low, so only a retire can change anything.
      if (retire) begin
        head_load      = 1'b1;
        skid_clear     = 1'b1;
        skid_valid_nxt = 1'b0;
      end else begin
        head_load = 1'b0;
      end
    end else if (head_valid) begin
      if (retire && accept) begin
        head_load = 1'b1;
      end else if (retire) begin
        head_clear     = 1'b1;
        head_valid_nxt = 1'b0;
      end else if (accept) begin
        skid_load      = 1'b1;
        skid_valid_nxt = 1'b1;
      end else begin
        head_load = 1'b0;
      end
    end else begin
      if (accept) begin
        head_load      = 1'b1;
        head_valid_nxt = 1'b1;
      end else begin
        head_load = 1'b0;
      end
    end
  end

  pipe_entry_reg #(.W(PW), .NOP_VAL(NOP_PAYLOAD)) u_head (
    .clk   (clk),
    .reset (reset),
    .load  (head_load),
    .clear (head_clear),
    .d     (head_d),
    .q     (head_q)
  );

  // Head valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_valid <= 1'b0;
    end else begin
      head_valid <= head_valid_nxt;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      pipe_entry_reg #(.W(PW), .NOP_VAL(NOP_PAYLOAD)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_pl),
        .q     (skid_q)
      );

      // Skid valid flag and registered in_ready (high during reset too).
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          skid_valid <= 1'b0;
          in_ready_q <= 1'b1;
        end else begin
          skid_valid <= skid_valid_nxt;
          in_ready_q <= !skid_valid_nxt;
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_q     = NOP_PAYLOAD;
      assign skid_valid = 1'b0;
      assign in_ready   = !head_valid || out_ready;
    end
  endgenerate

  assign out_valid = head_valid;
  assign {out_ctrl, out_data, out_regdst} = head_q;
  assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, directed
// vectors, expected entries queued by the stimulus and checked by a monitor.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int DW = NUM_DATA_DEF*DATA_W_DEF;
  localparam logic [7:0] NOP = 8'h01;
  localparam logic [108:0] BUBBLE = {8'h01, 101'd0};

  logic clk = 1'b0;
  logic reset;
  logic [1:0]          flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0][7:0]     in_ctrl, out_ctrl;
  logic [1:0][DW-1:0]  in_data, out_data;
  logic [1:0][4:0]     in_regdst, out_regdst;
  logic [1:0][1:0]     occ;

  payload_t q0[$];
  payload_t q1[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1)) dut_skid (
    .clk(clk), .reset(reset), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]),
    .in_data(in_data[0]), .in_regdst(in_regdst[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]),
    .out_data(out_data[0]), .out_regdst(out_regdst[0]), .occupancy(occ[0])
  );

  pipe_stage_reg #(.SKID(0)) dut_noskid (
    .clk(clk), .reset(reset), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]),
    .in_data(in_data[1]), .in_regdst(in_regdst[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]),
    .out_data(out_data[1]), .out_regdst(out_regdst[1]), .occupancy(occ[1])
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic payload_t mk(input logic [7:0] c, input int i);
    payload_t p;
    p.ctrl    = c;
    p.data[0] = 32'(i);
    p.data[1] = 32'hA5A5_0000 + 32'(i);
    p.data[2] = 32'h5A5A_0000 + 32'(i);
    p.regdst  = 5'(i + 1);
    return p;
  endfunction

  task automatic send(input int k, input logic v, input payload_t p);
    in_valid[k] = v;
    {in_ctrl[k], in_data[k], in_regdst[k]} = p;
  endtask

  task automatic push(input int k, input payload_t p);
    if (k == 0) q0.push_back(p);
    else        q1.push_back(p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops and compares on each retire, checks the bubble rule.
  always @(negedge clk) begin
    payload_t e;
    for (int k = 0; k < 2; k++) begin
      if (out_valid[k] && out_ready[k]) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          n_vec++;
          n_err++;
          $display("FAIL retire_unexpected dut%0d: got ctrl %0h, expected no entry", k, out_ctrl[k]);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("retire_dut%0d", k), {out_ctrl[k], out_data[k], out_regdst[k]}, e);
        end
      end
      if (!out_valid[k])
        chk($sformatf("bubble_dut%0d", k), {out_ctrl[k], out_data[k], out_regdst[k]}, BUBBLE);
    end
    chk("noskid_occ_le1", 128'(occ[1] <= 2'd1), 128'(1));
  end

  task automatic stream(input int k);
    out_ready[k] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(k, 1'b1, mk(8'(8'h10 + i), i));
      push(k, mk(8'(8'h10 + i), i));
      @(negedge clk);
      chk("stream_in_ready", in_ready[k], 1'b1);
      if (i > 0) begin
        chk("stream_no_gap", out_valid[k], 1'b1);
        chk("stream_latency", out_ctrl[k], 8'(8'h10 + i - 1));
      end
      tick();
    end
    send(k, 1'b0, mk(8'hEE, 99));
    @(negedge clk);
    chk("stream_last_valid", out_valid[k], 1'b1);
    chk("stream_last_occ", occ[k], 2'd1);
    tick();
    @(negedge clk);
    chk("stream_drained_occ", occ[k], 2'd0);
    tick();
  endtask

  initial begin
    reset = 1'b0; flush = '0; in_valid = '0; out_ready = '0;
    in_ctrl = '0; in_data = '0; in_regdst = '0;
    // 1. Reset with random inputs.
    for (int c = 0; c < 3; c++) begin
      in_valid = 2'($urandom); out_ready = 2'($urandom); flush = 2'($urandom);
      in_ctrl = 16'($urandom); in_regdst = 10'($urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("rst_out_valid", out_valid, 2'b00);
      chk("rst_out_ctrl", out_ctrl, {NOP, NOP});
      chk("rst_out_data", out_data, '0);
      chk("rst_out_regdst", out_regdst, '0);
      chk("rst_occ", occ, 4'd0);
      chk("rst_in_ready_skid", in_ready[0], 1'b1);
      tick();
    end
    in_valid = '0; out_ready = '0; flush = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 2'b11);
    tick();

    // 2. Streaming, SKID=1.
    stream(0);

    // 3. Stall/skid, SKID=1.
    out_ready[0] = 1'b0;
    send(0, 1'b1, mk(8'h22, 1)); push(0, mk(8'h22, 1));
    @(negedge clk); chk("skid_a_in_ready", in_ready[0], 1'b1); tick();
    send(0, 1'b1, mk(8'h33, 2)); push(0, mk(8'h33, 2));
    @(negedge clk); chk("skid_a_head", out_ctrl[0], 8'h22); chk("skid_occ1", occ[0], 2'd1); tick();
    send(0, 1'b0, mk(8'hEE, 0));
    @(negedge clk);
    chk("skid_occ2", occ[0], 2'd2); chk("skid_in_ready0", in_ready[0], 1'b0);
    chk("skid_head_held", out_ctrl[0], 8'h22); tick();
    out_ready[0] = 1'b1;
    @(negedge clk); chk("skid_full_in_ready", in_ready[0], 1'b0); tick();
    @(negedge clk);
    chk("skid_b_head", out_ctrl[0], 8'h33); chk("skid_b_occ1", occ[0], 2'd1);
    chk("skid_b_in_ready", in_ready[0], 1'b1); tick();
    @(negedge clk); chk("skid_empty_occ", occ[0], 2'd0); tick();

    // 4. Flush priority, SKID=1 (D, E, C are never retired).
    out_ready[0] = 1'b0;
    send(0, 1'b1, mk(8'h44, 3)); tick();
    send(0, 1'b1, mk(8'h55, 4)); tick();
    send(0, 1'b1, mk(8'h66, 5)); flush[0] = 1'b1;
    @(negedge clk); chk("flush_pre_occ", occ[0], 2'd2); tick();
    flush[0] = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", out_valid[0], 1'b0); chk("flush_out_ctrl", out_ctrl[0], NOP);
    chk("flush_occ", occ[0], 2'd0); chk("flush_in_ready", in_ready[0], 1'b1); tick();
    @(negedge clk); chk("flush_c_dropped", out_valid[0], 1'b0);
    send(0, 1'b1, mk(8'h77, 6)); flush[0] = 1'b1;
    @(negedge clk); chk("flush_acc_in_ready", in_ready[0], 1'b1); tick();
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    @(negedge clk);
    chk("flush_acc_dropped", out_valid[0], 1'b0); chk("flush_acc_occ", occ[0], 2'd0); tick();

    // 5. Async reset mid-stall, SKID=1.
    out_ready[0] = 1'b0;
    send(0, 1'b1, mk(8'h88, 7)); tick();
    send(0, 1'b1, mk(8'h99, 8)); tick();
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("areset_pre_occ", occ[0], 2'd2); chk("areset_pre_ctrl", out_ctrl[0], 8'h88);
    #2 reset = 1'b0;
    #1;
    chk("areset_out_valid", out_valid[0], 1'b0); chk("areset_out_ctrl", out_ctrl[0], NOP);
    chk("areset_out_data", out_data[0], '0); chk("areset_out_regdst", out_regdst[0], 5'd0);
    chk("areset_occ", occ[0], 2'd0); chk("areset_in_ready", in_ready[0], 1'b1);
    #1 reset = 1'b1;
    tick();
    @(negedge clk); chk("areset_post_occ", occ[0], 2'd0); tick();

    // 6. SKID=0: streaming and stall.
    stream(1);
    out_ready[1] = 1'b0;
    send(1, 1'b1, mk(8'h22, 11)); push(1, mk(8'h22, 11));
    @(negedge clk); chk("ns_a_in_ready", in_ready[1], 1'b1); tick();
    send(1, 1'b1, mk(8'h33, 12));
    @(negedge clk);
    chk("ns_stall_in_ready", in_ready[1], 1'b0); chk("ns_head", out_ctrl[1], 8'h22);
    chk("ns_occ1", occ[1], 2'd1); tick();
    out_ready[1] = 1'b1; push(1, mk(8'h33, 12));
    #1 chk("ns_comb_in_ready", in_ready[1], 1'b1);
    @(negedge clk); chk("ns_head_a", out_ctrl[1], 8'h22); tick();
    in_valid[1] = 1'b0;
    @(negedge clk); chk("ns_head_b", out_ctrl[1], 8'h33); chk("ns_b_occ", occ[1], 2'd1); tick();
    @(negedge clk); chk("ns_empty_occ", occ[1], 2'd0); chk("ns_empty_valid", out_valid[1], 1'b0);
    tick();

    chk("q_skid_drained", 128'(q0.size()), 128'(0));
    chk("q_noskid_drained", 128'(q1.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
